// File: rtl/misr_pkg.sv
// misr_pkg: shared types and helpers for the MISR response analyzer.
//   state_t      : analyzer FSM states (IDLE, RUN, CHECK, DONE)
//   DEFAULT_POLY : default feedback taps for an 8-bit signature
//   misr_next()  : one compaction step on a signature of up to MISR_MAX_W bits
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0]  DEFAULT_POLY = 8'h1D;
  localparam int unsigned MISR_MAX_W   = 64;

  typedef logic [MISR_MAX_W-1:0] misr_word_t;

  // Shift left, fold POLY back in when the bit shifted out of position
  // width-1 was set, XOR in the new data. Bits above width are cleared.
  function automatic misr_word_t misr_next(input misr_word_t  sig,
                                           input misr_word_t  data,
                                           input misr_word_t  poly,
                                           input int unsigned width);
    misr_word_t msb_word;
    misr_word_t fb;
    msb_word = sig >> (width - 1);
    fb       = msb_word[0] ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & ~({MISR_MAX_W{1'b1}} << width);
  endfunction

endpackage

// File: rtl/misr_core.sv
// misr_core: signature register of the MISR.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-low reset (loads SEED)
//   load  in  reload SEED (priority over shift)
//   shift in  perform one compaction step with data
//   data  in  WIDTH bits to compact
//   sig   out WIDTH bits, current signature
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(misr_next(misr_word_t'(r_sig), misr_word_t'(data),
                                   misr_word_t'(POLY), WIDTH));

  always_ff @(posedge clk) begin
    if (!rst)       r_sig <= SEED;
    else if (load)  r_sig <= SEED;
    else if (shift) r_sig <= w_next;
  end

  assign sig = r_sig;

endmodule

// File: rtl/misr_response_analyzer.sv
// misr_response_analyzer: compacts CUT responses into a MISR signature over
// PATTERN_COUNT enabled cycles, then compares against a golden signature.
//   clk       in  rising-edge clock
//   rst       in  synchronous active-low reset
//   start     in  begin a session (honoured in IDLE or DONE)
//   en        in  capture resp this cycle (RUN only)
//   resp      in  WIDTH, CUT response
//   resp_mask in  WIDTH, only with MISR_XMASK_EN: set bits compact as 0
//   golden    in  WIDTH, expected final signature, sampled in CHECK
//   signature out WIDTH, current MISR contents
//   busy      out high in RUN and CHECK
//   done      out high in DONE
//   pass      out valid while done: signature matched golden
// Optional feature macro: MISR_XMASK_EN (X-masking of response bits).
module misr_response_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED          = '0,
  parameter int               PATTERN_COUNT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] resp,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int CNT_W = $clog2(PATTERN_COUNT + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_sig;

`ifdef MISR_XMASK_EN
  assign w_data = resp & ~resp_mask;
`else
  assign w_data = resp;
`endif

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .data  (w_data),
    .sig   (w_sig)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (en) begin
          w_shift = 1'b1;
          if (r_cnt == CNT_W'(PATTERN_COUNT - 1)) w_next_state = CHECK;
        end
      end
      CHECK:   w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // cnt stops at PATTERN_COUNT once RUN is left; no wrap possible
  always_ff @(posedge clk) begin
    if (!rst)         r_cnt <= '0;
    else if (w_load)  r_cnt <= '0;
    else if (w_shift) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                  r_pass <= 1'b0;
    else if (r_state == CHECK) r_pass <= (w_sig == golden);
    else if (w_load)           r_pass <= 1'b0;
  end

  assign signature = w_sig;
  assign busy      = (r_state == RUN) || (r_state == CHECK);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;

endmodule

// File: tb/tb_misr_response_analyzer.sv
module tb_misr_response_analyzer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       en;
  logic [7:0] resp;
  logic [7:0] resp_mask;
  logic [7:0] golden;

  logic [7:0] sig9, sig4, sig1;
  logic       busy9, busy4, busy1;
  logic       done9, done4, done1;
  logic       pass9, pass4, pass1;

  int n_tests = 0;
  int n_fail  = 0;

  misr_response_analyzer #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .PATTERN_COUNT(9)) u9 (
    .clk(clk), .rst(rst), .start(start), .en(en), .resp(resp),
`ifdef MISR_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .golden(golden), .signature(sig9), .busy(busy9), .done(done9), .pass(pass9)
  );

  misr_response_analyzer #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .PATTERN_COUNT(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .en(en), .resp(resp),
`ifdef MISR_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .golden(golden), .signature(sig4), .busy(busy4), .done(done4), .pass(pass4)
  );

  misr_response_analyzer #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .PATTERN_COUNT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .en(en), .resp(resp),
`ifdef MISR_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .golden(golden), .signature(sig1), .busy(busy1), .done(done1), .pass(pass1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic [7:0] resp;
    logic [7:0] sig;
    logic       busy;
    logic       done;
  } vec_t;

  // Reference compaction step written from the rule: double, drop the
  // carry out of bit 7 and fold the taps back in when it was set, add data mod 2.
  function automatic int ref_step(int s, int d);
    int r;
    r = (s * 2) % 256;
    if (s >= 128) r = r ^ 'h1D;
    return r ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic get(int sel, output logic [7:0] s, output logic b, output logic d,
                     output logic p);
    case (sel)
      9:       begin s = sig9; b = busy9; d = done9; p = pass9; end
      4:       begin s = sig4; b = busy4; d = done4; p = pass4; end
      default: begin s = sig1; b = busy1; d = done1; p = pass1; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; en = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_table(string name, int sel, vec_t v[$]);
    logic [7:0] s;
    logic       b, d, p;
    foreach (v[i]) begin
      en = v[i].en; resp = v[i].resp;
      tick();
      get(sel, s, b, d, p);
      chk($sformatf("%s_sig[%0d]", name, i), s, v[i].sig);
      chk($sformatf("%s_busy[%0d]", name, i), 8'(b), 8'(v[i].busy));
      chk($sformatf("%s_done[%0d]", name, i), 8'(d), 8'(v[i].done));
    end
    en = 1'b0;
  endtask

  initial begin
    vec_t shift_v[$];
    vec_t gap_v[$];
    logic [7:0] gap_en;
    logic [7:0] s;
    logic       b, d, p;
    int m, k, cyc;
    bit g_eq;

    rst = 1'b0; start = 1'b0; en = 1'b0; resp = '0; resp_mask = '0; golden = '0;

    // shift chain on PATTERN_COUNT=9: 01 then zeros; feedback on the 9th edge
    shift_v.push_back('{1'b1, 8'h01, 8'h01, 1'b1, 1'b0});
    for (int i = 1; i < 8; i++)
      shift_v.push_back('{1'b1, 8'h00, 8'(1 << i), 1'b1, 1'b0});
    shift_v.push_back('{1'b1, 8'h00, 8'h1D, 1'b1, 1'b0});  // last update, enters CHECK
    shift_v.push_back('{1'b0, 8'h00, 8'h1D, 1'b0, 1'b1});  // DONE

    // en gaps on PATTERN_COUNT=4
    gap_en = 8'b0101_1001;  // bit i = en of cycle i: 1,0,0,1,1,0,1
    m = 0;
    for (int i = 0; i < 7; i++) begin
      if (gap_en[i]) m = ref_step(m, 1);
      gap_v.push_back('{gap_en[i], 8'h01, 8'(m), 1'b1, 1'b0});
    end
    gap_v.push_back('{1'b0, 8'h01, 8'h0F, 1'b0, 1'b1});

    // reset state
    do_reset();
    chk("rst_sig", sig9, 8'h00);
    chk("rst_busy", 8'(busy9), 8'h00);
    chk("rst_done", 8'(done9), 8'h00);
    chk("rst_pass", 8'(pass9), 8'h00);

    // en/resp activity in IDLE has no effect
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; resp = 8'hA5 ^ 8'(i);
      tick();
      chk("idle_sig", sig9, 8'h00);
      chk("idle_busy", 8'(busy9), 8'h00);
    end
    en = 1'b0;

    // matching session
    golden = 8'h1D;
    do_start();
    chk("start_busy", 8'(busy9), 8'h01);
    run_table("chain", 9, shift_v);
    chk("chain_pass", 8'(pass9), 8'h01);
    tick();
    chk("chain_hold_done", 8'(done9), 8'h01);
    chk("chain_hold_pass", 8'(pass9), 8'h01);

    // mismatching session, then restart from DONE clears done/pass
    do_reset();
    golden = 8'h1C;
    do_start();
    run_table("mis", 9, shift_v);
    chk("mis_pass", 8'(pass9), 8'h00);
    golden = 8'h1D;
    do_start();
    chk("mis_restart_done", 8'(done9), 8'h00);
    chk("mis_restart_pass", 8'(pass9), 8'h00);
    chk("mis_restart_sig", sig9, 8'h00);
    chk("mis_restart_busy", 8'(busy9), 8'h01);

    // en gaps
    do_reset();
    golden = 8'h0F;
    do_start();
    run_table("gap", 4, gap_v);
    chk("gap_pass", 8'(pass4), 8'h01);

    // reset mid-RUN, start ignored while RUN
    do_reset();
    do_start();
    m = 0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; en = 1'b1; resp = 8'(i + 3);
      tick();
      m = ref_step(m, i + 3);
      chk("midrun_sig", sig9, 8'(m));
      chk("midrun_busy", 8'(busy9), 8'h01);
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1; en = 1'b0;
    chk("midrst_sig", sig9, 8'h00);
    chk("midrst_busy", 8'(busy9), 8'h00);
    chk("midrst_done", 8'(done9), 8'h00);
    en = 1'b1; resp = 8'h77;
    tick();
    chk("midrst_idle_sig", sig9, 8'h00);
    en = 1'b0;

    // single-pattern session; with masking the upper nibble is dropped
    do_reset();
    golden = 8'h0F;
    do_start();
`ifdef MISR_XMASK_EN
    resp = 8'hFF; resp_mask = 8'hF0;
`else
    resp = 8'h0F; resp_mask = 8'h00;
`endif
    en = 1'b1;
    tick();
    en = 1'b0; resp_mask = 8'h00;
    chk("one_sig", sig1, 8'h0F);
    chk("one_busy", 8'(busy1), 8'h01);
    tick();
    chk("one_done", 8'(done1), 8'h01);
    chk("one_pass", 8'(pass1), 8'h01);

    // randomized sessions on PATTERN_COUNT=4 against the reference model
    do_reset();
    for (int sess = 0; sess < 20; sess++) begin
      m = 0; k = 0;
      // golden decided after the model finishes is too late,
      // so pick a candidate now and compare expectation at the end
      g_eq   = ($urandom % 2) == 1;
      golden = 8'($urandom);
      do_start();
      chk("rnd_start_sig", sig4, 8'h00);
      cyc = 0;
      while (k < 4 && cyc < 200) begin
        en = ($urandom % 2) == 1; resp = 8'($urandom);
        if (en && k == 3 && g_eq) golden = 8'(ref_step(m, int'(resp)));
        tick();
        if (en) begin
          m = ref_step(m, int'(resp));
          k++;
        end
        cyc++;
        get(4, s, b, d, p);
        chk("rnd_sig", s, 8'(m));
        chk("rnd_busy", 8'(b), 8'h01);
      end
      if (k < 4) begin
        n_tests++; n_fail++;
        $display("FAIL rnd_timeout actual=%0d required=4", k);
      end
      en = 1'b0;
      tick();
      chk("rnd_done", 8'(done4), 8'h01);
      chk("rnd_pass", 8'(pass4), 8'((golden == 8'(m)) ? 1 : 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
